// File: rtl/mips_mem_pkg.sv
// Shared size encodings and FSM state type for the MIPS32 data-memory path.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        IDLE,
        RMW_WR
    } lsu_state_t;

endpackage

// File: rtl/load_extend.sv
// Load lane select with sign or zero extension (little-endian lanes).
module load_extend
    import mips_mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        unique case (i_addr)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
        endcase
        w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_data = i_word;
        if (i_size == SZ_BYTE)
            o_data = {{24{i_signed & w_byte[7]}}, w_byte};
        else if (i_size == SZ_HALF)
            o_data = {{16{i_signed & w_half[15]}}, w_half};
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: lane extraction on loads, read-modify-write for sub-word stores.
// Define MISALIGN_TRAP_EN to flag misaligned half/word accesses instead of aligning them.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ReqValid,
    input  logic              ReqWrite,
    input  logic [1:0]        ReqSize,
    input  logic              ReqSigned,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [31:0]       ReqWData,
    output logic              Stall,
    output logic [31:0]       LoadData,
    output logic              LoadValid,
    output logic              AddrErr,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemWData,
    input  logic [31:0]       MemRData
);

    lsu_state_t        r_state;
    logic [31:0]       r_load_data;
    logic              r_load_valid;
    logic [31:0]       r_merge;
    logic [ADDR_W-1:0] r_addr;

    logic              w_idle;
    logic              w_rmw;
    logic              w_is_word;
    logic              w_misalign;
    logic [1:0]        w_lane;
    logic              w_go;
    logic              w_sub_st;
    logic [ADDR_W-1:0] w_waddr;
    logic [31:0]       w_ext;
    logic [31:0]       w_merge;

    assign w_idle    = (r_state == IDLE) && !reset;
    assign w_rmw     = (r_state == RMW_WR) && !reset;
    assign w_is_word = ReqSize[1];
    assign w_waddr   = {ReqAddr[ADDR_W-1:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = ((ReqSize == SZ_HALF) && ReqAddr[0]) ||
                        (w_is_word && (ReqAddr[1:0] != 2'b00));
    assign w_lane     = ReqAddr[1:0];
`else
    // Misaligned halves/words silently drop the low address bits.
    assign w_misalign = 1'b0;
    assign w_lane     = w_is_word            ? 2'b00 :
                        (ReqSize == SZ_HALF) ? {ReqAddr[1], 1'b0} :
                                               ReqAddr[1:0];
`endif

    assign w_go     = w_idle && ReqValid && !w_misalign;
    assign w_sub_st = w_go && ReqWrite && !w_is_word;

    assign AddrErr  = w_idle && ReqValid && w_misalign;
    assign Stall    = w_sub_st;
    assign MemRead  = w_go && (!ReqWrite || !w_is_word);
    assign MemWrite = w_rmw || (w_go && ReqWrite && w_is_word);
    assign MemAddr  = (r_state == RMW_WR) ? r_addr : w_waddr;
    assign MemWData = (r_state == RMW_WR) ? r_merge : ReqWData;

    assign LoadData  = r_load_data;
    assign LoadValid = r_load_valid;

    load_extend u_ext (
        .i_word   (MemRData),
        .i_addr   (w_lane),
        .i_size   (w_is_word ? SZ_WORD : ReqSize),
        .i_signed (ReqSigned),
        .o_data   (w_ext)
    );

    always_comb begin
        w_merge = MemRData;
        if (ReqSize == SZ_BYTE) begin
            unique case (w_lane)
                2'd0: w_merge[7:0]   = ReqWData[7:0];
                2'd1: w_merge[15:8]  = ReqWData[7:0];
                2'd2: w_merge[23:16] = ReqWData[7:0];
                2'd3: w_merge[31:24] = ReqWData[7:0];
            endcase
        end else if (w_lane[1]) begin
            w_merge[31:16] = ReqWData[15:0];
        end else begin
            w_merge[15:0] = ReqWData[15:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_load_data  <= '0;
            r_load_valid <= 1'b0;
            r_merge      <= '0;
            r_addr       <= '0;
        end else begin
            r_load_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_go && !ReqWrite) begin
                        r_load_data  <= w_ext;
                        r_load_valid <= 1'b1;
                    end
                    if (w_sub_st) begin
                        r_merge <= w_merge;
                        r_addr  <= w_waddr;
                        r_state <= RMW_WR;
                    end
                end
                RMW_WR: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word memory model and load scoreboard.
module tb_load_store_unit;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              ReqValid;
    logic              ReqWrite;
    logic [1:0]        ReqSize;
    logic              ReqSigned;
    logic [ADDR_W-1:0] ReqAddr;
    logic [31:0]       ReqWData;
    logic              Stall;
    logic [31:0]       LoadData;
    logic              LoadValid;
    logic              AddrErr;
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] MemAddr;
    logic [31:0]       MemWData;
    logic [31:0]       MemRData;

    logic [31:0] mem [16];
    logic [31:0] exp_q[$];
    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .ReqValid  (ReqValid),
        .ReqWrite  (ReqWrite),
        .ReqSize   (ReqSize),
        .ReqSigned (ReqSigned),
        .ReqAddr   (ReqAddr),
        .ReqWData  (ReqWData),
        .Stall     (Stall),
        .LoadData  (LoadData),
        .LoadValid (LoadValid),
        .AddrErr   (AddrErr),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .MemAddr   (MemAddr),
        .MemWData  (MemWData),
        .MemRData  (MemRData)
    );

    assign MemRData = mem[MemAddr[5:2]];

    always @(posedge clk)
        if (MemWrite) mem[MemAddr[5:2]] <= MemWData;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic v, input logic w, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] d);
        ReqValid  = v;
        ReqWrite  = w;
        ReqSize   = sz;
        ReqSigned = sg;
        ReqAddr   = a;
        ReqWData  = d;
    endtask

    task automatic load(input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] e);
        @(negedge clk);
        req(1'b1, 1'b0, sz, sg, a, 32'h0);
        exp_q.push_back(e);
        #1;
        chk("ld_rd", {31'b0, MemRead}, 32'h1);
        chk("ld_addr", MemAddr, {a[31:2], 2'b00});
        chk("ld_stall", {31'b0, Stall}, 32'h0);
    endtask

    // Scoreboard: every LoadValid pulse must match the oldest pending load.
    always @(negedge clk) begin
        if (LoadValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra", LoadData, 32'hx);
            end else begin
                chk("sb_data", LoadData, exp_q.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[5] = 32'h80F0_1234;
        reset = 1'b1;
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_rd", {31'b0, MemRead}, 32'h0);
        chk("rst_wr", {31'b0, MemWrite}, 32'h0);
        chk("rst_stall", {31'b0, Stall}, 32'h0);
        chk("rst_err", {31'b0, AddrErr}, 32'h0);
        chk("rst_lv", {31'b0, LoadValid}, 32'h0);
        chk("rst_ld", LoadData, 32'h0);
        reset = 1'b0;
        req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);

        load(2'b00, 1'b1, 32'h16, 32'hFFFF_FFF0);
        load(2'b01, 1'b0, 32'h16, 32'h0000_80F0);
        load(2'b01, 1'b1, 32'h16, 32'hFFFF_80F0);
        load(2'b10, 1'b0, 32'h14, 32'h80F0_1234);
        load(2'b00, 1'b0, 32'h17, 32'h0000_0080);
        load(2'b00, 1'b1, 32'h14, 32'h0000_0034);
        load(2'b11, 1'b1, 32'h14, 32'h80F0_1234);

        @(negedge clk);
        req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        #1;
        chk("idle_rd", {31'b0, MemRead}, 32'h0);
        @(posedge clk);
        #1;
        chk("idle_lv", {31'b0, LoadValid}, 32'h0);

        @(negedge clk);
        req(1'b1, 1'b1, 2'b00, 1'b0, 32'h15, 32'h0000_00AB);
        #1;
        chk("sb0_stall", {31'b0, Stall}, 32'h1);
        chk("sb0_rd", {31'b0, MemRead}, 32'h1);
        chk("sb0_wr", {31'b0, MemWrite}, 32'h0);
        @(negedge clk);
        chk("sb1_wr", {31'b0, MemWrite}, 32'h1);
        chk("sb1_rd", {31'b0, MemRead}, 32'h0);
        chk("sb1_stall", {31'b0, Stall}, 32'h0);
        chk("sb1_addr", MemAddr, 32'h14);
        chk("sb1_wdata", MemWData, 32'h80F0_AB34);
        chk("sb1_lv", {31'b0, LoadValid}, 32'h0);
        load(2'b10, 1'b0, 32'h14, 32'h80F0_AB34);

        @(negedge clk);
        req(1'b1, 1'b1, 2'b10, 1'b0, 32'h14, 32'hDEAD_BEEF);
        #1;
        chk("sw_wr", {31'b0, MemWrite}, 32'h1);
        chk("sw_rd", {31'b0, MemRead}, 32'h0);
        chk("sw_stall", {31'b0, Stall}, 32'h0);
        chk("sw_wdata", MemWData, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        chk("sw_lv", {31'b0, LoadValid}, 32'h0);
        load(2'b10, 1'b0, 32'h14, 32'hDEAD_BEEF);

        @(negedge clk);
        req(1'b1, 1'b1, 2'b01, 1'b0, 32'h16, 32'h0000_1357);
        #1;
        chk("sh0_stall", {31'b0, Stall}, 32'h1);
        @(negedge clk);
        chk("sh1_wdata", MemWData, 32'h1357_BEEF);
        load(2'b10, 1'b0, 32'h14, 32'h1357_BEEF);

        @(negedge clk);
        req(1'b1, 1'b1, 2'b10, 1'b0, 32'h14, 32'h80F0_1234);

`ifdef MISALIGN_TRAP_EN
        @(negedge clk);
        req(1'b1, 1'b0, 2'b01, 1'b1, 32'h15, 32'h0);
        #1;
        chk("mis_err", {31'b0, AddrErr}, 32'h1);
        chk("mis_rd", {31'b0, MemRead}, 32'h0);
        chk("mis_wr", {31'b0, MemWrite}, 32'h0);
        chk("mis_stall", {31'b0, Stall}, 32'h0);
        @(posedge clk);
        #1;
        chk("mis_lv", {31'b0, LoadValid}, 32'h0);
        @(negedge clk);
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h16, 32'h0);
        #1;
        chk("misw_err", {31'b0, AddrErr}, 32'h1);
`else
        load(2'b01, 1'b1, 32'h15, 32'h0000_1234);
        #0;
        chk("mis_err", {31'b0, AddrErr}, 32'h0);
        load(2'b01, 1'b0, 32'h15, 32'h0000_1234);
        load(2'b10, 1'b0, 32'h16, 32'h80F0_1234);
`endif

        @(negedge clk);
        req(1'b1, 1'b1, 2'b01, 1'b0, 32'h16, 32'h0000_CAFE);
        #1;
        chk("rmw_stall", {31'b0, Stall}, 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rr_wr", {31'b0, MemWrite}, 32'h0);
        chk("rr_stall", {31'b0, Stall}, 32'h0);
        chk("rr_lv", {31'b0, LoadValid}, 32'h0);
        chk("rr_ld", LoadData, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("rr_mem", mem[5], 32'h80F0_1234);
        reset = 1'b0;
        req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        load(2'b10, 1'b0, 32'h14, 32'h80F0_1234);

        @(negedge clk);
        req(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        chk("sb_left", exp_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
